cache_controller: RTL
=====================

Name: cache_controller

Overview:
Sequencing FSM for the write-back, write-allocate, set-associative cache.
- Decodes processor read/write requests against the set's hit/dirty status.
- Drives the 5-bit set control word {write_en, set_valid, set_dirty, strategy_en, offset_sel}.
- Runs the word-serial write-back and refill transfers to memory, and stalls the processor until the access completes.

Parameters:
OFFSET_WIDTH, 4 (`CACHE_B), byte-offset bits per line; WORDS = 2**(OFFSET_WIDTH-2) = 4 words/line
SET_WIDTH, 2 (`CACHE_S), set-index bits
TAG_WIDTH, 26 (`CACHE_T), equals 32-SET_WIDTH-OFFSET_WIDTH

Ports:
clk_i  in  1  single clock, all state on rising edge
rst_i  in  1  asynchronous, active-low reset
read_en_i  in  1  processor read request, held until stall_o low
write_en_i  in  1  processor write request, held until stall_o low
addr_i  in  32  processor address, stable while request held
hit_i  in  1  selected set hit
dirty_i  in  1  victim line dirty
tag_dirty_line_i  in  TAG_WIDTH  tag of dirty victim line
mem_ready_i  in  1  memory completed current word (read data valid this cycle)
control_o  out  5  {write_en, set_valid, set_dirty, strategy_en, offset_sel}
mem_addr_o  out  32  word address of current memory transfer
mem_read_en_o  out  1  refill word request
mem_write_en_o  out  1  write-back word request
stall_o  out  1  processor must hold request

Behaviour:
- States: IDLE, WRITEBACK, ALLOCATE. Word counter cnt, width OFFSET_WIDTH-2.
- Reset (async, rst_i=0): state=IDLE, cnt=0. All outputs are combinational from state; in IDLE with no request every output is 0.
- Request precedence: read_en_i and write_en_i both high is treated as a write.
- IDLE, no request: control_o=0, stall_o=0.
- IDLE, read hit: control_o=0, stall_o=0. Data returns same cycle (0 extra latency).
- IDLE, write hit: control_o=5'b11111 (write, valid, dirty, strategy, processor offset/data), stall_o=0. Committed on this edge.
- IDLE, miss: stall_o=1 and control_o=0 in the same cycle.
  - Next state is WRITEBACK if dirty_i=1, else ALLOCATE.
  - cnt=0.
- WRITEBACK:
  - mem_write_en_o=1, mem_addr_o={tag_dirty_line_i, addr_i index, cnt, 2'b00}.
  - control_o=0, so offset_sel=0 and the set reads the word at mem_addr_o.
  - stall_o=1.
  - On mem_ready_i: cnt+1. If cnt==WORDS-1, go to ALLOCATE and cnt wraps to 0.
- ALLOCATE:
  - mem_read_en_o=1, mem_addr_o={addr_i[31:OFFSET_WIDTH], cnt, 2'b00}, stall_o=1.
  - When mem_ready_i=1: control_o write_en=1, set_dirty=0, offset_sel=0. set_valid and strategy_en are 1 only when cnt==WORDS-1. Otherwise control_o=0.
  - On the last word: go to IDLE, cnt=0.
  - The next cycle re-evaluates in IDLE. The access now hits; a pending write then performs its write-hit cycle.
- Latency: clean miss = WORDS memory words + 1 cycle; dirty miss = 2*WORDS words + 1 cycle.
- mem_ready_i is ignored in IDLE and never advances cnt there.
- Request deasserted mid-miss: the transfer completes regardless. No abort.
- hit_i/dirty_i are ignored outside IDLE.
- Reset mid-transfer: immediate return to IDLE, memory enables drop asynchronously, partial line stays invalid.
- Only one memory enable is high at any time.

Decomposition:
- cache_pkg: state enum (IDLE, WRITEBACK, ALLOCATE), control-word bit-position localparams, named control constants CTRL_NONE, CTRL_WRITE_HIT, CTRL_REFILL, CTRL_REFILL_LAST.
- Sub-module line_word_counter: clear/increment, last-word flag, wraps at WORDS-1.

Test Plan:
1. Read hit: read_en_i=1, addr_i=0x1234, hit_i=1 -> stall_o=0, control_o=0, no memory enable, same cycle.
2. Write hit: write_en_i=1, hit_i=1 -> control_o=5'b11111 for exactly 1 cycle, stall_o=0.
3. Clean read miss on 0x1234, hit_i=0, dirty_i=0, mem_ready_i every 2nd cycle:
   - mem_addr_o steps 0x1230, 0x1234, 0x1238, 0x123C with mem_read_en_o=1.
   - control_o=5'b10000 on the first three ready cycles, 5'b11010 on the fourth.
   - Then IDLE with stall_o=0 once hit_i=1.
4. Dirty write miss: addr_i=0x1234, dirty_i=1, tag_dirty_line_i=0x5A:
   - Write-back addresses 0x16B0, 0x16B4, 0x16B8, 0x16BC with mem_write_en_o=1.
   - Then refill 0x1230..0x123C.
   - Then one 5'b11111 write cycle.
   - stall_o high for exactly the 8 transfers plus miss cycle.
5. Assert rst_i=0 during the second refill word -> state IDLE, cnt=0, mem_read_en_o=0, stall_o=0 immediately. After release, the same request restarts the refill at 0x1230.
6. Drop read_en_i after the first refill word -> the refill still issues all 4 words, then returns to IDLE with all outputs 0.

Source files
------------

// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared types and constants for the write-back, write-allocate cache
// sequencer.
//   - state_t     : sequencer state (IDLE, WRITEBACK, ALLOCATE)
//   - CTRL_*_BIT  : bit positions inside the 5-bit set control word
//                   {write_en, set_valid, set_dirty, strategy_en, offset_sel}
//   - CTRL_*      : named control words driven by the sequencer
//   - refill_ctrl : control word for a refill word that memory has delivered
// -----------------------------------------------------------------------------
package cache_pkg;

   // Default geometry: 16-byte lines (4 words) and 4 sets.
   localparam int CACHE_B = 4;
   localparam int CACHE_S = 2;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2
   } state_t;

   localparam int CTRL_W = 5;

   localparam int CTRL_WRITE_EN_BIT    = 4;
   localparam int CTRL_SET_VALID_BIT   = 3;
   localparam int CTRL_SET_DIRTY_BIT   = 2;
   localparam int CTRL_STRATEGY_EN_BIT = 1;
   localparam int CTRL_OFFSET_SEL_BIT  = 0;

   localparam logic [CTRL_W-1:0] CTRL_NONE = '0;

   // Processor write into a resident line: the line becomes valid and dirty,
   // replacement state is updated and the word/offset come from the processor.
   localparam logic [CTRL_W-1:0] CTRL_WRITE_HIT =
      CTRL_W'((1 << CTRL_WRITE_EN_BIT)    |
              (1 << CTRL_SET_VALID_BIT)   |
              (1 << CTRL_SET_DIRTY_BIT)   |
              (1 << CTRL_STRATEGY_EN_BIT) |
              (1 << CTRL_OFFSET_SEL_BIT));

   // Refill word: written from memory at the memory-side offset. The line is
   // only marked valid (and the replacement state touched) on the last word,
   // so a partially refilled line never looks resident.
   localparam logic [CTRL_W-1:0] CTRL_REFILL =
      CTRL_W'(1 << CTRL_WRITE_EN_BIT);

   localparam logic [CTRL_W-1:0] CTRL_REFILL_LAST =
      CTRL_W'((1 << CTRL_WRITE_EN_BIT)  |
              (1 << CTRL_SET_VALID_BIT) |
              (1 << CTRL_STRATEGY_EN_BIT));

   function automatic logic [CTRL_W-1:0] refill_ctrl(input logic last_word);
      return last_word ? CTRL_REFILL_LAST : CTRL_REFILL;
   endfunction

endpackage

// File: rtl/cache_controller_line_word_counter.sv
// -----------------------------------------------------------------------------
// line_word_counter
// Word index within a cache line for the word-serial memory transfers.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset, clears the count
//   clear  in   synchronous clear (held while the sequencer is idle)
//   inc    in   advance one word; wraps to 0 after the last word
//   cnt    out  current word index, CNT_W bits
//   last   out  cnt is the last word of the line
// -----------------------------------------------------------------------------
module line_word_counter #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt,
   output logic             last
);

   localparam int WORDS = 2 ** CNT_W;

   assign last = (cnt == CNT_W'(WORDS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= last ? '0 : cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/cache_controller.sv
// -----------------------------------------------------------------------------
// cache_controller
// Sequencer for a write-back, write-allocate, set-associative cache. Decodes
// processor requests against the selected set's hit/dirty status, drives the
// set control word and runs word-serial write-back and refill transfers,
// stalling the processor until the access can complete as a hit.
// Ports:
//   clk_i             in   clock, rising edge
//   rst_i             in   asynchronous active-low reset
//   read_en_i         in   processor read request (held while stalled)
//   write_en_i        in   processor write request (held while stalled)
//   addr_i            in   processor byte address
//   hit_i             in   selected set hit
//   dirty_i           in   victim line dirty
//   tag_dirty_line_i  in   tag of the dirty victim line
//   mem_ready_i       in   memory finished the current word
//   control_o         out  {write_en, set_valid, set_dirty, strategy_en, offset_sel}
//   mem_addr_o        out  byte address of the current memory word
//   mem_read_en_o     out  refill word request
//   mem_write_en_o    out  write-back word request
//   stall_o           out  processor must hold its request
// All outputs are combinational from state and inputs; while rst_i is low
// they are all forced to 0.
// -----------------------------------------------------------------------------
module cache_controller
   import cache_pkg::*;
#(
   parameter int OFFSET_WIDTH = CACHE_B,
   parameter int SET_WIDTH    = CACHE_S,
   parameter int TAG_WIDTH    = 32 - SET_WIDTH - OFFSET_WIDTH
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 read_en_i,
   input  logic                 write_en_i,
   input  logic [31:0]          addr_i,
   input  logic                 hit_i,
   input  logic                 dirty_i,
   input  logic [TAG_WIDTH-1:0] tag_dirty_line_i,
   input  logic                 mem_ready_i,
   output logic [CTRL_W-1:0]    control_o,
   output logic [31:0]          mem_addr_o,
   output logic                 mem_read_en_o,
   output logic                 mem_write_en_o,
   output logic                 stall_o
);

   localparam int CNT_W = OFFSET_WIDTH - 2;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             last_word;
   logic             req;
   logic [SET_WIDTH-1:0] set_index;

   // Byte-within-word and word-within-line bits of the processor address
   // never reach memory: transfers are always whole, word-aligned lines.
   logic unused_addr_bits;
   assign unused_addr_bits = ^addr_i[OFFSET_WIDTH-1:0];

   // A simultaneous read and write is handled as a write; both simply count
   // as a request for miss detection.
   assign req       = read_en_i | write_en_i;
   assign set_index = addr_i[OFFSET_WIDTH+SET_WIDTH-1:OFFSET_WIDTH];

   line_word_counter #(
      .CNT_W (CNT_W)
   ) u_word_cnt (
      .clk   (clk_i),
      .rst_n (rst_i),
      .clear (state == IDLE),
      .inc   (mem_ready_i && (state != IDLE)),
      .cnt   (cnt),
      .last  (last_word)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (req && !hit_i) begin
                  state <= dirty_i ? WRITEBACK : ALLOCATE;
               end
            end
            WRITEBACK: begin
               if (mem_ready_i && last_word) begin
                  state <= ALLOCATE;
               end
            end
            ALLOCATE: begin
               if (mem_ready_i && last_word) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      control_o      = CTRL_NONE;
      mem_addr_o     = '0;
      mem_read_en_o  = 1'b0;
      mem_write_en_o = 1'b0;
      stall_o        = 1'b0;
      if (rst_i) begin
         case (state)
            IDLE: begin
               if (req && !hit_i) begin
                  stall_o = 1'b1;
               end else if (write_en_i && hit_i) begin
                  control_o = CTRL_WRITE_HIT;
               end
            end
            WRITEBACK: begin
               // control word stays 0 so the set reads out the victim word
               // addressed by the memory-side offset.
               stall_o        = 1'b1;
               mem_write_en_o = 1'b1;
               mem_addr_o     = {tag_dirty_line_i, set_index, cnt, 2'b00};
            end
            ALLOCATE: begin
               stall_o       = 1'b1;
               mem_read_en_o = 1'b1;
               mem_addr_o    = {addr_i[31:OFFSET_WIDTH], cnt, 2'b00};
               if (mem_ready_i) begin
                  control_o = refill_ctrl(last_word);
               end
            end
            default: begin
               control_o = CTRL_NONE;
            end
         endcase
      end
   end

endmodule
